// File: rtl/pipe_reg_chain.sv
// Elastic register chain with bubble collapse, backpressure and per-stage flush.
// Stage 0 is the input (youngest) side, stage STAGES-1 the output (oldest) side.
module pipe_reg_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    input  logic                          flush_valid,
    input  logic [IDX_W-1:0]              flush_stage,
    output logic [$clog2(STAGES+1)-1:0]   occupancy,
    output logic [15:0]                   kill_count
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic [15:0]       kill_q;
    logic [15:0]       kill_d;

    logic [STAGES-1:0] kill_sel;
    logic [STAGES-1:0] adv;
    logic              accept0;
    logic              in_fire;
    logic [OCC_W-1:0]  kill_n;
    logic [16:0]       kill_sum;
    int                fidx;

    // Out-of-range flush indices clamp to the oldest stage.
    always_comb begin
        fidx = (int'(flush_stage) >= STAGES) ? STAGES - 1 : int'(flush_stage);
        for (int i = 0; i < STAGES; i++) begin
            kill_sel[i] = flush_valid && (i <= fidx);
        end
    end

    always_comb begin
        out_valid         = rst && valid_q[STAGES-1] && !kill_sel[STAGES-1];
        adv               = '0;
        adv[STAGES-1]     = out_valid && out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = valid_q[i] && !kill_sel[i] && (!valid_q[i+1] || adv[i+1]);
        end
        accept0  = !valid_q[0] || adv[0];
        in_ready = rst && !flush_valid && accept0;
        in_fire  = in_valid && in_ready;
    end

    assign out_data = data_q[STAGES-1];

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = data_q[i];
        end
        if (in_fire) begin
            valid_d[0] = 1'b1;
            data_d[0]  = in_data;
        end else if (adv[0] || kill_sel[0]) begin
            valid_d[0] = 1'b0;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (adv[i-1]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = data_q[i-1];
            end else if (adv[i] || kill_sel[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        occ_d  = '0;
        kill_n = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d  = occ_d + OCC_W'(valid_d[i]);
            kill_n = kill_n + OCC_W'(valid_q[i] && kill_sel[i]);
        end
        kill_sum = {1'b0, kill_q} + 17'(kill_n);
        kill_d   = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            kill_q  <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            kill_q  <= kill_d;
        end
    end

    // Payloads carry no reset; they are only meaningful under a set valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    assign occupancy  = occ_q;
    assign kill_count = kill_q;

endmodule
